// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared state encoding and counter width helper for the PLL reset sequencer
package pll_seq_pkg;
  typedef enum logic [2:0] {
    OFF       = 3'd0,
    RESET     = 3'd1,
    WAIT_LOCK = 3'd2,
    STABLE    = 3'd3,
    RUN       = 3'd4
  } state_t;

  function automatic int cyc_w(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return $clog2(m + 1);
  endfunction
endpackage

// File: rtl/pll_seq_sync_debounce.sv
// pll_seq_sync_debounce: 2-flop switch synchronizer, debounced when PLL_RESET_SEQUENCER_DEBOUNCE_EN is defined
module pll_seq_sync_debounce #(
  parameter int   DEBOUNCE_CYCLES = 16,
  parameter logic RST_VAL         = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [1:0] sync;
  // two-flop synchronizer, resets to 0
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync <= '0;
    else sync <= {sync[0], d};
`ifdef PLL_RESET_SEQUENCER_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);
  logic [DW-1:0] cnt;
  logic filt;
  // filter follows the synchronized value only after it has differed for DEBOUNCE_CYCLES straight cycles
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt  <= '0;
      filt <= RST_VAL;
    end else if (sync[1] == filt) cnt <= '0;
    else if (cnt == DMAX) begin
      filt <= sync[1];
      cnt  <= '0;
    end else cnt <= cnt + DW'(1);
  assign q = filt;
`else
  assign q = sync[1];
`endif
endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: sequences PLL PWRDWN/RST from board switches and gates downstream reset on stable lock (option: PLL_RESET_SEQUENCER_DEBOUNCE_EN)
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES      = 4,
  parameter int LOCK_TIMEOUT    = 1024,
  parameter int STABLE_CYCLES   = 16,
  parameter int CNT_W           = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sw_pwrdwn,
  input  logic             sw_rst,
  input  logic             pll_locked,
  output logic             pll_pwrdwn,
  output logic             pll_rst,
  output logic             sys_rst_n,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retry_cnt,
  output logic [CNT_W-1:0] loss_cnt
);
  localparam int CW = cyc_w(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam logic [CW-1:0] RST_LD = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] LT_MAX = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] ST_MAX = CW'(STABLE_CYCLES - 1);

  state_t st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] retry_n, loss_n;
  logic pd_s, rs_s, lk_s;
  logic [1:0] lk_sync;

  pll_seq_sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RST_VAL(1'b1)) u_pd (
    .clk(clk), .rst_n(rst_n), .d(sw_pwrdwn), .q(pd_s)
  );
  pll_seq_sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RST_VAL(1'b1)) u_rs (
    .clk(clk), .rst_n(rst_n), .d(sw_rst), .q(rs_s)
  );

  // lock is only synchronized, never debounced, so a dropout is seen as fast as possible
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lk_sync <= '0;
    else lk_sync <= {lk_sync[0], pll_locked};
  assign lk_s = lk_sync[1];

  // next state: power-down beats reset switch beats lock events
  always_comb begin
    st_n    = st;
    cnt_n   = cnt;
    retry_n = retry_cnt;
    loss_n  = loss_cnt;
    if (st == OFF) begin
      if (!pd_s && !rs_s) begin
        st_n  = RESET;
        cnt_n = RST_LD;
      end
    end else if (pd_s) begin
      st_n  = OFF;
      cnt_n = '0;
    end else if (rs_s) begin
      st_n  = RESET;
      cnt_n = RST_LD;
    end else begin
      case (st)
        RESET:
          if (cnt == '0) st_n = WAIT_LOCK;
          else cnt_n = cnt - CW'(1);
        WAIT_LOCK:
          if (lk_s) begin
            st_n  = STABLE;
            cnt_n = '0;
          end else if (cnt == LT_MAX) begin
            st_n    = RESET;
            cnt_n   = RST_LD;
            retry_n = retry_cnt + CNT_W'(retry_cnt != '1);
          end else cnt_n = cnt + CW'(1);
        STABLE:
          if (!lk_s) begin
            st_n  = WAIT_LOCK;
            cnt_n = '0;
          end else if (cnt == ST_MAX) begin
            st_n  = RUN;
            cnt_n = '0;
          end else cnt_n = cnt + CW'(1);
        RUN:
          if (!lk_s) begin
            st_n   = RESET;
            cnt_n  = RST_LD;
            loss_n = loss_cnt + CNT_W'(loss_cnt != '1);
          end
        default: st_n = OFF;
      endcase
    end
  end

  // state, counters and outputs registered together so outputs track the state without decode glitches
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st         <= OFF;
      cnt        <= '0;
      retry_cnt  <= '0;
      loss_cnt   <= '0;
      pll_pwrdwn <= 1'b1;
      pll_rst    <= 1'b1;
      sys_rst_n  <= 1'b0;
    end else begin
      st         <= st_n;
      cnt        <= cnt_n;
      retry_cnt  <= retry_n;
      loss_cnt   <= loss_n;
      pll_pwrdwn <= st_n == OFF;
      pll_rst    <= st_n == OFF || st_n == RESET;
      sys_rst_n  <= st_n == RUN;
    end

  assign state = st;
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: directed plus random checks of the PLL reset sequencer against a phase-timer model
module tb_pll_reset_sequencer;
  localparam int RC = 4;
  localparam int LT = 1024;
  localparam int SC = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sw_pwrdwn = 1'b1;
  logic sw_rst = 1'b1;
  logic pll_locked = 1'b0;

  logic pd_a, rs_a, sy_a, pd_b, rs_b, sy_b;
  logic [2:0] st_a, st_b;
  logic [7:0] rt_a, ls_a;
  logic [1:0] rt_b, ls_b;

  always #5 clk = ~clk;

  pll_reset_sequencer dut_a (
    .clk(clk), .rst_n(rst_n), .sw_pwrdwn(sw_pwrdwn), .sw_rst(sw_rst), .pll_locked(pll_locked),
    .pll_pwrdwn(pd_a), .pll_rst(rs_a), .sys_rst_n(sy_a), .state(st_a), .retry_cnt(rt_a), .loss_cnt(ls_a)
  );

  pll_reset_sequencer #(.CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .sw_pwrdwn(sw_pwrdwn), .sw_rst(sw_rst), .pll_locked(pll_locked),
    .pll_pwrdwn(pd_b), .pll_rst(rs_b), .sys_rst_n(sy_b), .state(st_b), .retry_cnt(rt_b), .loss_cnt(ls_b)
  );

  // model: phase number plus cycles spent in the phase, counted upward
  typedef struct {
    int ph;
    int el;
    int retry;
    int loss;
  } m_t;

  m_t ma, mb;
  bit p1, p2, r1, r2, l1, l2;
  int n_chk = 0;
  int n_fail = 0;

  function automatic m_t step(m_t m, bit pd, bit rs, bit lk, int cmax);
    m_t n;
    n = m;
    if (m.ph == 0) begin
      if (!pd && !rs) begin n.ph = 1; n.el = 0; end
    end else if (pd) begin
      n.ph = 0; n.el = 0;
    end else if (rs) begin
      n.ph = 1; n.el = 0;
    end else if (m.ph == 1) begin
      n.el = m.el + 1;
      if (n.el == RC) begin n.ph = 2; n.el = 0; end
    end else if (m.ph == 2) begin
      if (lk) begin n.ph = 3; n.el = 0; end
      else begin
        n.el = m.el + 1;
        if (n.el == LT) begin
          n.ph = 1; n.el = 0;
          n.retry = (m.retry < cmax) ? m.retry + 1 : cmax;
        end
      end
    end else if (m.ph == 3) begin
      if (!lk) begin n.ph = 2; n.el = 0; end
      else begin
        n.el = m.el + 1;
        if (n.el == SC) begin n.ph = 4; n.el = 0; end
      end
    end else if (!lk) begin
      n.ph = 1; n.el = 0;
      n.loss = (m.loss < cmax) ? m.loss + 1 : cmax;
    end
    return n;
  endfunction

  task automatic mreset();
    ma = '{0, 0, 0, 0};
    mb = '{0, 0, 0, 0};
    {p1, p2, r1, r2, l1, l2} = '0;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cmp();
    chk("state_a", st_a, ma.ph);
    chk("pwrdwn_a", pd_a, ma.ph == 0);
    chk("pllrst_a", rs_a, ma.ph <= 1);
    chk("sysrst_a", sy_a, ma.ph == 4);
    chk("retry_a", rt_a, ma.retry);
    chk("loss_a", ls_a, ma.loss);
    chk("state_b", st_b, mb.ph);
    chk("pwrdwn_b", pd_b, mb.ph == 0);
    chk("pllrst_b", rs_b, mb.ph <= 1);
    chk("sysrst_b", sy_b, mb.ph == 4);
    chk("retry_b", rt_b, mb.retry);
    chk("loss_b", ls_b, mb.loss);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) mreset();
    else begin
      ma = step(ma, p2, r2, l2, 255);
      mb = step(mb, p2, r2, l2, 3);
      p2 = p1; p1 = sw_pwrdwn;
      r2 = r1; r1 = sw_rst;
      l2 = l1; l1 = pll_locked;
    end
    #1 cmp();
  endtask

  task automatic wait_st(int s, int bound, string tag);
    int n;
    n = 0;
    while (st_a !== 3'(s) && n < bound) begin tick(); n++; end
    chk(tag, st_a, s);
  endtask

  initial begin
    int n, rst_hi, rt0, ls0;
    mreset();
    // power-up
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (17) tick();
    sw_pwrdwn = 1'b0;
    sw_rst = 1'b0;
    n = 0;
    while (pd_a && n < 10) begin tick(); n++; end
    chk("pwrdwn_fall_lat", n, 3);
    rst_hi = 0;
    for (int i = 0; i < 20 && rs_a; i++) begin rst_hi++; tick(); end
    chk("pll_rst_width", rst_hi, RC);
    repeat (23) tick();
    pll_locked = 1'b1;
    n = 0;
    while (!sy_a && n < 100) begin tick(); n++; end
    chk("sysrst_rise_lat", n, SC + 3);
    // loss in RUN
    pll_locked = 1'b0;
    n = 0;
    while (sy_a && n < 10) begin tick(); n++; end
    chk("loss_sysrst_lat", n, 3);
    chk("loss_cnt_one", ls_a, 1);
    // repeated lock timeouts
    repeat (5 * (LT + RC) + 10) tick();
    chk("retry_five", rt_a, 5);
    chk("retry_sat", rt_b, 3);
    // lock glitch during STABLE
    repeat ($urandom_range(1, 50)) tick();
    pll_locked = 1'b1;
    wait_st(3, 1100, "reach_stable");
    repeat ($urandom_range(1, 12)) tick();
    rt0 = rt_a;
    ls0 = ls_a;
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    wait_st(2, 10, "glitch_wait_lock");
    chk("glitch_retry", rt_a, rt0);
    chk("glitch_loss", ls_a, ls0);
    wait_st(4, 40, "glitch_run");
    // random lock activity and switch pulses
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) pll_locked = ~pll_locked;
      sw_rst = ($urandom_range(0, 59) == 0);
      sw_pwrdwn = ($urandom_range(0, 149) == 0);
      tick();
    end
    // power-down coinciding with lock loss in RUN
    sw_rst = 1'b0;
    sw_pwrdwn = 1'b0;
    pll_locked = 1'b1;
    wait_st(4, 200, "prio_run");
    ls0 = ls_a;
    sw_pwrdwn = 1'b1;
    pll_locked = 1'b0;
    repeat (3) tick();
    chk("prio_state", st_a, 0);
    chk("prio_pwrdwn", pd_a, 1);
    chk("prio_loss", ls_a, ls0);
    // asynchronous reset in WAIT_LOCK
    sw_pwrdwn = 1'b0;
    wait_st(2, 100, "arst_wait_lock");
    #2 rst_n = 1'b0;
    #1;
    mreset();
    chk("arst_state", st_a, 0);
    chk("arst_pwrdwn", pd_a, 1);
    chk("arst_pllrst", rs_a, 1);
    chk("arst_sysrst", sy_a, 0);
    chk("arst_retry", rt_a, 0);
    chk("arst_loss", ls_a, 0);
    chk("arst_retry_b", rt_b, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    pll_locked = 1'b1;
    repeat (40) tick();
    chk("post_arst_run", st_a, 4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
